// File: rtl/iob_rs232_rx_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iob_rs232_rx_filter_pkg
//  Description : Shared types and constants for the RS232 receive line
//                conditioner: break-detector state encoding, glitch counter
//                width and the default break length derived from FREQ/BAUD.
//  Revision    : 1.0 - initial release
// ============================================================================
package iob_rs232_rx_filter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        BRK  = 2'd2
    } brk_state_t;

    localparam int GLITCH_CNT_W = 8;

    // One UART frame is 11 bit times; a low lasting that long cannot be data.
    function automatic int brk_cyc_default(input int freq, input int baud);
        return 11 * (freq / baud);
    endfunction

endpackage

`default_nettype wire

// File: rtl/iob_rs232_break_det.sv
`default_nettype none
// ============================================================================
//  Module      : iob_rs232_break_det
//  Description : Line-break detector. Declares a break once the filtered
//                receive line has been low for BRK_CYC enabled cycles and
//                holds it until the line returns high.
//  Ports       : clk_i       - system clock
//                arst_i      - asynchronous active-high reset
//                cke_i       - clock enable, all state holds when low
//                rxd_i       - filtered receive line
//                break_o     - high while the break is in progress
//                break_evt_o - one-cycle pulse on break entry
//  Revision    : 1.0 - initial release
// ============================================================================
module iob_rs232_break_det
    import iob_rs232_rx_filter_pkg::*;
#(
    parameter int BRK_CYC = 20
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic cke_i,
    input  logic rxd_i,
    output logic break_o,
    output logic break_evt_o
);

    localparam int                BCNT_W      = $clog2(BRK_CYC + 1);
    localparam logic [BCNT_W-1:0] c_BCNT_LAST = BCNT_W'(BRK_CYC - 1);

    brk_state_t        r_state;
    brk_state_t        w_state_nxt;
    logic [BCNT_W-1:0] r_bcnt;
    logic [BCNT_W-1:0] w_bcnt_nxt;
    logic              r_break;
    logic              r_break_evt;

    // bcnt counts low cycles including the one that caused IDLE->LOW, so the
    // LOW->BRK transition lands exactly BRK_CYC cycles after the fall.
    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        case (r_state)
            IDLE: begin
                if (!rxd_i) begin
                    w_state_nxt = LOW;
                    w_bcnt_nxt  = BCNT_W'(1);
                end
            end
            LOW: begin
                if (rxd_i) begin
                    w_state_nxt = IDLE;
                    w_bcnt_nxt  = '0;
                end else if (r_bcnt == c_BCNT_LAST) begin
                    w_state_nxt = BRK;
                end else begin
                    w_bcnt_nxt = r_bcnt + BCNT_W'(1);
                end
            end
            BRK: begin
                if (rxd_i) begin
                    w_state_nxt = IDLE;
                    w_bcnt_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_bcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state     <= IDLE;
            r_bcnt      <= '0;
            r_break     <= 1'b0;
            r_break_evt <= 1'b0;
        end else if (cke_i) begin
            r_state     <= w_state_nxt;
            r_bcnt      <= w_bcnt_nxt;
            r_break     <= (w_state_nxt == BRK);
            r_break_evt <= (r_state == LOW) && (w_state_nxt == BRK);
        end
    end

    assign break_o     = r_break;
    assign break_evt_o = r_break_evt;

endmodule

`default_nettype wire

// File: rtl/iob_rs232_rx_filter.sv
`default_nettype none
// ============================================================================
//  Module      : iob_rs232_rx_filter
//  Description : RS232 receive line conditioner. Synchronises the raw pad,
//                rejects level changes shorter than GLITCH_CYC cycles,
//                counts rejected glitches (saturating) and optionally
//                detects line breaks.
//  Config      : IOB_RS232_RX_FILTER_BREAK_EN - builds the break detector;
//                when undefined break_o/break_evt_o are tied low.
//  Ports       : clk_i        - system clock
//                arst_i       - asynchronous active-high reset
//                cke_i        - clock enable, all state holds when low
//                rxd_i        - raw asynchronous pad input (idles high)
//                clr_i        - synchronous clear of glitch_cnt_o
//                rxd_o        - filtered receive data
//                break_o      - high while a break is in progress
//                break_evt_o  - one-cycle pulse on break entry
//                glitch_cnt_o - saturating count of rejected glitches
//  Revision    : 1.0 - initial release
// ============================================================================
module iob_rs232_rx_filter
    import iob_rs232_rx_filter_pkg::*;
#(
    parameter int FREQ       = 100000000,
    parameter int BAUD       = 115200,
    parameter int GLITCH_CYC = 4,
    parameter int BRK_CYC    = brk_cyc_default(FREQ, BAUD)
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic                    cke_i,
    input  logic                    rxd_i,
    input  logic                    clr_i,
    output logic                    rxd_o,
    output logic                    break_o,
    output logic                    break_evt_o,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt_o
);

    localparam logic [3:0] c_CNT_LAST = 4'(GLITCH_CYC - 1);

    logic                    r_sync1;
    logic                    r_sync2;
    logic                    r_rxd;
    logic [3:0]              r_cnt;
    logic [GLITCH_CNT_W-1:0] r_gcnt;
    logic                    w_diff;
    logic                    w_accept;
    logic                    w_glitch;
    logic                    w_unused_cfg;

    assign w_diff   = (r_sync2 != r_rxd);
    assign w_accept = w_diff && (r_cnt == c_CNT_LAST);
    // A non-zero count with the levels equal again means a candidate edge
    // reverted before it was accepted.
    assign w_glitch = !w_diff && (r_cnt != 4'd0);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rxd   <= 1'b1;
            r_cnt   <= 4'd0;
        end else if (cke_i) begin
            r_sync1 <= rxd_i;
            r_sync2 <= r_sync1;
            if (w_accept) begin
                r_rxd <= r_sync2;
                r_cnt <= 4'd0;
            end else if (w_diff) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= 4'd0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_gcnt <= '0;
        end else if (cke_i) begin
            if (clr_i) begin
                r_gcnt <= '0;
            end else if (w_glitch && (r_gcnt != '1)) begin
                r_gcnt <= r_gcnt + GLITCH_CNT_W'(1);
            end
        end
    end

    assign rxd_o        = r_rxd;
    assign glitch_cnt_o = r_gcnt;

`ifdef IOB_RS232_RX_FILTER_BREAK_EN
    iob_rs232_break_det #(
        .BRK_CYC (BRK_CYC)
    ) u_break_det (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .cke_i       (cke_i),
        .rxd_i       (r_rxd),
        .break_o     (break_o),
        .break_evt_o (break_evt_o)
    );
`else
    assign break_o     = 1'b0;
    assign break_evt_o = 1'b0;
`endif

    // Frequency/baud only shape the default break length.
    assign w_unused_cfg = (FREQ > 0) && (BAUD > 0) && (BRK_CYC >= 2);

endmodule

`default_nettype wire

// File: tb/tb_iob_rs232_rx_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iob_rs232_rx_filter
//  Description : Self-checking bench for iob_rs232_rx_filter. Expected edges
//                of rxd_o / break_o / break_evt_o are queued with their
//                cycle numbers when the pad is driven and compared by a
//                monitor as they appear. A standalone break detector is also
//                exercised so break timing is covered in every build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_rs232_rx_filter;
    import iob_rs232_rx_filter_pkg::*;

    localparam int GLITCH_CYC = 4;
    localparam int BRK_CYC    = 20;
    localparam int LAT        = 2 + GLITCH_CYC;

    logic clk = 1'b0;
    logic arst, cke, rxd, clr;
    logic rxd_o, break_o, break_evt_o;
    logic [GLITCH_CNT_W-1:0] glitch_cnt_o;
    logic bd_rst, bd_cke, bd_rxd, bd_break, bd_evt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int exp_gcnt = 0;

    typedef struct { int cyc; logic val; } ev_t;
    ev_t  q_rxd[$];
    ev_t  q_brk[$];
    int   q_evt[$];
    ev_t  ev;
    int   ev_cyc;
    bit   mon_en = 1'b0;
    logic p_rxd  = 1'b1;
    logic p_brk  = 1'b0;

    iob_rs232_rx_filter #(
        .FREQ       (100000000),
        .BAUD       (115200),
        .GLITCH_CYC (GLITCH_CYC),
        .BRK_CYC    (BRK_CYC)
    ) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .cke_i        (cke),
        .rxd_i        (rxd),
        .clr_i        (clr),
        .rxd_o        (rxd_o),
        .break_o      (break_o),
        .break_evt_o  (break_evt_o),
        .glitch_cnt_o (glitch_cnt_o)
    );

    iob_rs232_break_det #(
        .BRK_CYC (BRK_CYC)
    ) u_bd (
        .clk_i       (clk),
        .arst_i      (bd_rst),
        .cke_i       (bd_cke),
        .rxd_i       (bd_rxd),
        .break_o     (bd_break),
        .break_evt_o (bd_evt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every observed edge must match the queue head.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rxd_o !== p_rxd) begin
                n_checks++;
                if (q_rxd.size() == 0) begin
                    n_errors++;
                    $display("FAIL rxd_o_edge: changed to %b at cycle %0d, no change expected", rxd_o, cyc);
                end else begin
                    ev = q_rxd.pop_front();
                    if (ev.cyc != cyc || ev.val !== rxd_o) begin
                        n_errors++;
                        $display("FAIL rxd_o_edge: got %b at cycle %0d, expected %b at cycle %0d", rxd_o, cyc, ev.val, ev.cyc);
                    end
                end
            end
            if (break_o !== p_brk) begin
                n_checks++;
                if (q_brk.size() == 0) begin
                    n_errors++;
                    $display("FAIL break_o_edge: changed to %b at cycle %0d, no change expected", break_o, cyc);
                end else begin
                    ev = q_brk.pop_front();
                    if (ev.cyc != cyc || ev.val !== break_o) begin
                        n_errors++;
                        $display("FAIL break_o_edge: got %b at cycle %0d, expected %b at cycle %0d", break_o, cyc, ev.val, ev.cyc);
                    end
                end
            end
            if (break_evt_o !== 1'b0) begin
                n_checks++;
                if (q_evt.size() == 0) begin
                    n_errors++;
                    $display("FAIL break_evt_o: value %b at cycle %0d, no pulse expected", break_evt_o, cyc);
                end else begin
                    ev_cyc = q_evt.pop_front();
                    if (ev_cyc != cyc || break_evt_o !== 1'b1) begin
                        n_errors++;
                        $display("FAIL break_evt_o: value %b at cycle %0d, expected 1 at cycle %0d", break_evt_o, cyc, ev_cyc);
                    end
                end
            end
        end
        p_rxd = rxd_o;
        p_brk = break_o;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        arst = 1'b1; cke = 1'b1; rxd = 1'b1; clr = 1'b0;
        bd_rst = 1'b1; bd_cke = 1'b1; bd_rxd = 1'b1;
        step(3);
        n_checks++;
        if ({rxd_o, break_o, break_evt_o, glitch_cnt_o} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_errors++;
            $display("FAIL reset_active: got rxd=%b brk=%b evt=%b gcnt=%0d, expected 1 0 0 0", rxd_o, break_o, break_evt_o, glitch_cnt_o);
        end
        arst = 1'b0; bd_rst = 1'b0;
        step(3);
        n_checks++;
        if ({rxd_o, break_o, break_evt_o, glitch_cnt_o, bd_break, bd_evt} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_release: got rxd=%b brk=%b evt=%b gcnt=%0d bd=%b%b, expected 1 0 0 0 00", rxd_o, break_o, break_evt_o, glitch_cnt_o, bd_break, bd_evt);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_break_det_unit();
        int len;
        for (int li = 0; li < 3; li++) begin
            len = (li == 0) ? 19 : (li == 1) ? 20 : 25;
            bd_rxd = 1'b0;
            for (int k = 1; k <= len; k++) begin
                step(1);
                n_checks++;
                if (bd_break !== 1'(k >= BRK_CYC) || bd_evt !== 1'(k == BRK_CYC)) begin
                    n_errors++;
                    $display("FAIL bd_low%0d_k%0d: got brk=%b evt=%b, expected brk=%b evt=%b", len, k, bd_break, bd_evt, k >= BRK_CYC, k == BRK_CYC);
                end
            end
            bd_rxd = 1'b1;
            step(1);
            n_checks++;
            if (bd_break !== 1'b0 || bd_evt !== 1'b0) begin
                n_errors++;
                $display("FAIL bd_release%0d: got brk=%b evt=%b, expected 0 0", len, bd_break, bd_evt);
            end
            step(2);
        end
        // Clock-enable freeze across the would-be rise and on a pending pulse.
        bd_rxd = 1'b0;
        step(15);
        bd_cke = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            n_checks++;
            if (bd_break !== 1'b0) begin
                n_errors++;
                $display("FAIL bd_cke_hold_low: got brk=%b, expected 0", bd_break);
            end
        end
        bd_cke = 1'b1;
        step(5);
        bd_cke = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            n_checks++;
            if (bd_break !== 1'b1 || bd_evt !== 1'b1) begin
                n_errors++;
                $display("FAIL bd_cke_hold_evt: got brk=%b evt=%b, expected 1 1", bd_break, bd_evt);
            end
        end
        bd_cke = 1'b1;
        step(1);
        n_checks++;
        if (bd_break !== 1'b1 || bd_evt !== 1'b0) begin
            n_errors++;
            $display("FAIL bd_cke_resume: got brk=%b evt=%b, expected 1 0", bd_break, bd_evt);
        end
        bd_rxd = 1'b1;
        step(1);
        n_checks++;
        if (bd_break !== 1'b0) begin
            n_errors++;
            $display("FAIL bd_cke_release: got brk=%b, expected 0", bd_break);
        end
    endtask

    task automatic test_fall_latency();
        rxd = 1'b0;
        q_rxd.push_back('{cyc + LAT, 1'b0});
        step(10);
        rxd = 1'b1;
        q_rxd.push_back('{cyc + LAT, 1'b1});
        step(LAT + 4);
        n_checks++;
        if (q_rxd.size() + q_brk.size() + q_evt.size() != 0) begin
            n_errors++;
            $display("FAIL fall_latency_drain: %0d expected edges never seen, expected 0", q_rxd.size() + q_brk.size() + q_evt.size());
        end
    endtask

    task automatic test_glitch();
        rxd = 1'b0; step(3); rxd = 1'b1; step(8);
        exp_gcnt = 1;
        n_checks++;
        if (glitch_cnt_o !== 8'(exp_gcnt)) begin
            n_errors++;
            $display("FAIL glitch_3cyc: got %0d, expected %0d", glitch_cnt_o, exp_gcnt);
        end
        rxd = 1'b0; step(2); rxd = 1'b1; step(8);
        exp_gcnt = 2;
        n_checks++;
        if (glitch_cnt_o !== 8'(exp_gcnt)) begin
            n_errors++;
            $display("FAIL glitch_2cyc: got %0d, expected %0d", glitch_cnt_o, exp_gcnt);
        end
        clr = 1'b1; step(1); clr = 1'b0; step(1);
        exp_gcnt = 0;
        n_checks++;
        if (glitch_cnt_o !== 8'(exp_gcnt)) begin
            n_errors++;
            $display("FAIL glitch_clear: got %0d, expected %0d", glitch_cnt_o, exp_gcnt);
        end
        for (int i = 0; i < 300; i++) begin
            rxd = 1'b0; step(3); rxd = 1'b1; step(5);
            if (exp_gcnt < 255) exp_gcnt++;
        end
        step(3);
        n_checks++;
        if (glitch_cnt_o !== 8'(exp_gcnt)) begin
            n_errors++;
            $display("FAIL glitch_saturate: got %0d, expected %0d", glitch_cnt_o, exp_gcnt);
        end
        // Clear lands on the same edge the glitch is counted.
        rxd = 1'b0; step(3); rxd = 1'b1; step(2);
        clr = 1'b1; step(1); clr = 1'b0; step(3);
        exp_gcnt = 0;
        n_checks++;
        if (glitch_cnt_o !== 8'(exp_gcnt)) begin
            n_errors++;
            $display("FAIL glitch_clear_wins: got %0d, expected %0d", glitch_cnt_o, exp_gcnt);
        end
        rxd = 1'b0; step(3); rxd = 1'b1; step(8);
        exp_gcnt = 1;
        n_checks++;
        if (glitch_cnt_o !== 8'(exp_gcnt)) begin
            n_errors++;
            $display("FAIL glitch_after_clear: got %0d, expected %0d", glitch_cnt_o, exp_gcnt);
        end
    endtask

    task automatic test_cke();
        rxd = 1'b0;
        step(3);
        cke = 1'b0;
        step(10);
        n_checks++;
        if (rxd_o !== 1'b1 || glitch_cnt_o !== 8'(exp_gcnt)) begin
            n_errors++;
            $display("FAIL cke_freeze: got rxd=%b gcnt=%0d, expected 1 %0d", rxd_o, glitch_cnt_o, exp_gcnt);
        end
        // Three enabled edges remain before the pending fall is accepted.
        q_rxd.push_back('{cyc + 3, 1'b0});
        cke = 1'b1;
        step(6);
        rxd = 1'b1;
        q_rxd.push_back('{cyc + LAT, 1'b1});
        step(LAT + 4);
        n_checks++;
        if (q_rxd.size() + q_brk.size() + q_evt.size() != 0 || glitch_cnt_o !== 8'(exp_gcnt)) begin
            n_errors++;
            $display("FAIL cke_resume: %0d edges pending gcnt=%0d, expected 0 pending gcnt=%0d", q_rxd.size() + q_brk.size() + q_evt.size(), glitch_cnt_o, exp_gcnt);
        end
    endtask

`ifdef IOB_RS232_RX_FILTER_BREAK_EN
    task automatic test_break();
        rxd = 1'b0;
        q_rxd.push_back('{cyc + LAT, 1'b0});
        q_brk.push_back('{cyc + LAT + BRK_CYC, 1'b1});
        q_evt.push_back(cyc + LAT + BRK_CYC);
        step(30);
        rxd = 1'b1;
        q_rxd.push_back('{cyc + LAT, 1'b1});
        q_brk.push_back('{cyc + LAT + 1, 1'b0});
        step(LAT + 5);
        n_checks++;
        if (q_rxd.size() + q_brk.size() + q_evt.size() != 0) begin
            n_errors++;
            $display("FAIL break_30: %0d expected edges never seen, expected 0", q_rxd.size() + q_brk.size() + q_evt.size());
        end
    endtask

    task automatic test_break_boundary();
        int b;
        for (int len = BRK_CYC - 1; len <= BRK_CYC; len++) begin
            rxd = 1'b0;
            b = cyc;
            q_rxd.push_back('{b + LAT, 1'b0});
            step(len);
            rxd = 1'b1;
            q_rxd.push_back('{b + len + LAT, 1'b1});
            if (len >= BRK_CYC) begin
                q_brk.push_back('{b + LAT + BRK_CYC, 1'b1});
                q_evt.push_back(b + LAT + BRK_CYC);
                q_brk.push_back('{b + len + LAT + 1, 1'b0});
            end
            step(LAT + 5);
            n_checks++;
            if (q_rxd.size() + q_brk.size() + q_evt.size() != 0) begin
                n_errors++;
                $display("FAIL break_low%0d: %0d expected edges never seen, expected 0", len, q_rxd.size() + q_brk.size() + q_evt.size());
            end
        end
    endtask

    task automatic test_reset_mid_break();
        rxd = 1'b0;
        q_rxd.push_back('{cyc + LAT, 1'b0});
        q_brk.push_back('{cyc + LAT + BRK_CYC, 1'b1});
        q_evt.push_back(cyc + LAT + BRK_CYC);
        step(30);
        arst = 1'b1;
        q_rxd.push_back('{cyc, 1'b1});
        q_brk.push_back('{cyc, 1'b0});
        #1;
        n_checks++;
        if (break_o !== 1'b0 || rxd_o !== 1'b1 || break_evt_o !== 1'b0 || glitch_cnt_o !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_mid_break: got rxd=%b brk=%b evt=%b gcnt=%0d, expected 1 0 0 0", rxd_o, break_o, break_evt_o, glitch_cnt_o);
        end
        exp_gcnt = 0;
        step(2);
        arst = 1'b0;
        q_rxd.push_back('{cyc + LAT, 1'b0});
        q_brk.push_back('{cyc + LAT + BRK_CYC, 1'b1});
        q_evt.push_back(cyc + LAT + BRK_CYC);
        step(30);
        rxd = 1'b1;
        q_rxd.push_back('{cyc + LAT, 1'b1});
        q_brk.push_back('{cyc + LAT + 1, 1'b0});
        step(LAT + 5);
        n_checks++;
        if (q_rxd.size() + q_brk.size() + q_evt.size() != 0) begin
            n_errors++;
            $display("FAIL reset_restart: %0d expected edges never seen, expected 0", q_rxd.size() + q_brk.size() + q_evt.size());
        end
    endtask
`else
    task automatic test_no_break();
        rxd = 1'b0;
        q_rxd.push_back('{cyc + LAT, 1'b0});
        step(100);
        rxd = 1'b1;
        q_rxd.push_back('{cyc + LAT, 1'b1});
        step(LAT + 5);
        n_checks++;
        if (break_o !== 1'b0 || break_evt_o !== 1'b0 || q_rxd.size() != 0) begin
            n_errors++;
            $display("FAIL no_break: got brk=%b evt=%b pending=%0d, expected 0 0 0", break_o, break_evt_o, q_rxd.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_break_det_unit();
        test_fall_latency();
        test_glitch();
        test_cke();
`ifdef IOB_RS232_RX_FILTER_BREAK_EN
        test_break();
        test_break_boundary();
        test_reset_mid_break();
`else
        test_no_break();
`endif
        step(5);
        n_checks++;
        if (q_rxd.size() + q_brk.size() + q_evt.size() != 0) begin
            n_errors++;
            $display("FAIL final_drain: %0d expected edges never seen, expected 0", q_rxd.size() + q_brk.size() + q_evt.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
